// File: rtl/core_defs.sv
// Shared definitions for the MIPS-subset core front end: opcodes,
// fetch FSM encoding and the reset PC.
package core_defs;

  localparam logic [5:0] OP_ALU  = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] OP_HALT = 6'd63;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DECODE = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  // Sequential PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch unit.
// Priority: halt > j > (beq & zero) > sequential.
module next_pc_calc
  import core_defs::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] ir_field,
  input  logic        j,
  input  logic        beq,
  input  logic        halt,
  input  logic        zero,
  output logic [31:0] next_pc,
  output logic        go_halt
);

  logic [31:0] w_pc4;
  logic [31:0] w_jtarget;
  logic [31:0] w_boff;
  logic [31:0] w_btarget;

  assign w_pc4     = pc_plus4(pc);
  assign w_jtarget = {w_pc4[31:28], ir_field, 2'b00};
  assign w_boff    = {{14{ir_field[15]}}, ir_field[15:0], 2'b00};
  assign w_btarget = w_pc4 + w_boff;

  always_comb begin
    go_halt = 1'b0;
    next_pc = w_pc4;
    if (halt) begin
      go_halt = 1'b1;
      next_pc = pc;
    end else if (j) begin
      next_pc = w_jtarget;
    end else if (beq && zero) begin
      next_pc = w_btarget;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: issues word reads, latches the IR, hands the opcode to
// the control decoder and sequences the PC from its j/beq/halt result.
module instruction_fetch
  import core_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [5:0]  instruction,
  output logic [31:0] instr_word,
  output logic        instr_valid,
  output logic [31:0] pc,
  input  logic        j,
  input  logic        beq,
  input  logic        halt,
  input  logic        zero,
  input  logic        stall,
  output logic        halted
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_ir;
  logic [31:0]  w_next_pc;
  logic         w_go_halt;

  next_pc_calc u_next_pc (
    .pc       (r_pc),
    .ir_field (r_ir[25:0]),
    .j        (j),
    .beq      (beq),
    .halt     (halt),
    .zero     (zero),
    .next_pc  (w_next_pc),
    .go_halt  (w_go_halt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 32'd0;
    end else begin
      case (r_state)
        ST_FETCH: r_state <= ST_WAIT;
        ST_WAIT: begin
          // Responses are only accepted here, so stale data is dropped.
          if (imem_valid) begin
            r_ir    <= imem_rdata;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (!stall) begin
            if (w_go_halt) begin
              r_state <= ST_HALTED;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= ST_FETCH;
            end
          end
        end
        default: r_state <= ST_HALTED;
      endcase
    end
  end

  // Request is held low while reset is asserted even though the state is FETCH.
  assign imem_req    = (r_state == ST_FETCH) && !reset;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instruction = r_ir[31:26];
  assign instr_word  = r_ir;
  assign instr_valid = (r_state == ST_DECODE);
  assign halted      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: table of single-instruction vectors
// plus hand sequences for stall, halt and reset-during-wait.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [5:0]  instruction;
  logic [31:0] instr_word;
  logic        instr_valid;
  logic [31:0] pc;
  logic        j, beq, halt, zero, stall;
  logic        halted;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .instr_word  (instr_word),
    .instr_valid (instr_valid),
    .pc          (pc),
    .j           (j),
    .beq         (beq),
    .halt        (halt),
    .zero        (zero),
    .stall       (stall),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    logic        j, beq, halt, zero;
    logic [5:0]  op;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[15];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_req();
    for (int k = 0; k < 30 && !imem_req; k++) step();
    chk("req_seen", {31'd0, imem_req}, 32'd1);
  endtask

  // Executes one instruction from FETCH through the DECODE exit edge.
  task automatic run_vec(input vec_t v, input logic [31:0] start_pc, output int req_cyc);
    wait_req();
    req_cyc = cyc;
    chk("imem_addr", imem_addr, start_pc);
    step();
    chk("req_one_cycle", {31'd0, imem_req}, 32'd0);
    for (int k = 1; k < v.lat; k++) step();
    imem_valid = 1'b1;
    imem_rdata = v.rdata;
    step();
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    chk("instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("instruction", {26'd0, instruction}, {26'd0, v.op});
    chk("instr_word", instr_word, v.rdata);
    j = v.j; beq = v.beq; halt = v.halt; zero = v.zero;
    step();
    j = 1'b0; beq = 1'b0; halt = 1'b0; zero = 1'b0;
    chk("next_pc", pc, v.exp_pc);
    chk("instr_valid_drop", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, prev_rc, prev_lat, nreq;
    logic [31:0] cur_pc;
    vec_t hv;

    //           rdata          lat  j    beq  halt zero op  exp_pc
    tbl[0]  = '{32'h20010005, 1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd8,  32'h0000_0004};
    tbl[1]  = '{32'h08000010, 1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd2,  32'h0000_0040};
    tbl[2]  = '{32'h08000008, 2, 1'b1, 1'b0, 1'b0, 1'b0, 6'd2,  32'h0000_0020};
    tbl[3]  = '{32'h1000FFFE, 1, 1'b0, 1'b1, 1'b0, 1'b1, 6'd4,  32'h0000_001C};
    tbl[4]  = '{32'h08000008, 1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd2,  32'h0000_0020};
    tbl[5]  = '{32'h1000FFFE, 3, 1'b0, 1'b1, 1'b0, 1'b0, 6'd4,  32'h0000_0024};
    tbl[6]  = '{32'h8C000000, 1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd35, 32'h0000_0028};
    tbl[7]  = '{32'h08000004, 1, 1'b1, 1'b1, 1'b0, 1'b1, 6'd2,  32'h0000_0010};
    tbl[8]  = '{32'h08000000, 2, 1'b1, 1'b0, 1'b0, 1'b0, 6'd2,  32'h0000_0000};
    tbl[9]  = '{32'h1000FFFD, 1, 1'b0, 1'b1, 1'b0, 1'b1, 6'd4,  32'hFFFF_FFF8};
    tbl[10] = '{32'h08000000, 1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd2,  32'hF000_0000};
    tbl[11] = '{32'h08000010, 1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd2,  32'hF000_0040};
    tbl[12] = '{32'h0BFFFFFF, 1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd2,  32'hFFFF_FFFC};
    tbl[13] = '{32'h20010005, 3, 1'b0, 1'b0, 1'b0, 1'b0, 6'd8,  32'h0000_0000};
    tbl[14] = '{32'hAC000000, 1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd43, 32'h0000_0004};

    reset = 1'b1;
    imem_valid = 1'b1;          // stale response while in reset
    imem_rdata = 32'h1234_5678;
    j = 1'b0; beq = 1'b0; halt = 1'b0; zero = 1'b0; stall = 1'b0;
    step(); step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instruction", {26'd0, instruction}, 32'd0);
    chk("rst_instr_word", instr_word, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    reset = 1'b0;
    #1;

    // Table: PC chain, request spacing = latency + 2.
    cur_pc = 32'h0;
    prev_rc = 0;
    prev_lat = 0;
    for (int i = 0; i < 15; i++) begin
      run_vec(tbl[i], cur_pc, rc);
      if (i > 0) chk("req_gap", rc - prev_rc, prev_lat + 2);
      prev_rc = rc;
      prev_lat = tbl[i].lat;
      cur_pc = tbl[i].exp_pc;
    end
    // table ends at pc 4; return to 0 for the stall sequence
    hv = '{32'h08000000, 1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd2, 32'h0};
    run_vec(hv, cur_pc, rc);

    // Latency 5, stray valids in FETCH and DECODE, 3 stalled DECODE cycles.
    wait_req();
    chk("stall_addr", imem_addr, 32'h0);
    imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_valid = 1'b0; imem_rdata = 32'h0;
    for (int k = 0; k < 4; k++) step();
    chk("lat5_wait", {31'd0, instr_valid}, 32'd0);
    chk("lat5_ir_unchanged", instr_word, 32'h08000000);
    imem_valid = 1'b1; imem_rdata = 32'h2108_0003;
    stall = 1'b1;
    step();
    imem_rdata = 32'hBAD0_BAD0;   // stray valid held high through DECODE
    for (int k = 0; k < 3; k++) begin
      chk("stall_instr_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_ir", instr_word, 32'h2108_0003);
      chk("stall_pc", pc, 32'h0);
      step();
    end
    chk("stall_4th_valid", {31'd0, instr_valid}, 32'd1);
    chk("stall_4th_pc", pc, 32'h0);
    stall = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0;
    step();
    chk("stall_release_pc", pc, 32'h4);
    chk("stall_release_valid", {31'd0, instr_valid}, 32'd0);
    chk("stall_release_ir", instr_word, 32'h2108_0003);

    // Halt with every decode input high; halt wins.
    hv = '{32'hFC000000, 1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd63, 32'h4};
    run_vec(hv, 32'h4, rc);
    chk("halted", {31'd0, halted}, 32'd1);
    nreq = 0;
    imem_valid = 1'b1; imem_rdata = 32'h0000_0000;
    for (int k = 0; k < 20; k++) begin
      if (imem_req) nreq++;
      step();
    end
    imem_valid = 1'b0;
    chk("halt_no_req", nreq, 0);
    chk("halt_pc_held", pc, 32'h4);
    chk("halt_ir_held", instr_word, 32'hFC00_0000);
    chk("halt_still", {31'd0, halted}, 32'd1);
    chk("halt_no_valid", {31'd0, instr_valid}, 32'd0);
    reset = 1'b1;
    step();
    chk("halt_rst_pc", pc, 32'h0);
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);
    chk("halt_rst_req", {31'd0, imem_req}, 32'd0);
    reset = 1'b0;
    #1;
    chk("resume_req", {31'd0, imem_req}, 32'd1);

    // Reset asserted mid-WAIT, response arrives one cycle after release.
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rw_req", {31'd0, imem_req}, 32'd1);
    chk("rw_addr", imem_addr, 32'h0);
    imem_valid = 1'b1; imem_rdata = 32'h8C00_0000;
    step();
    imem_valid = 1'b0; imem_rdata = 32'h0;
    chk("rw_stale_ignored", {31'd0, instr_valid}, 32'd0);
    chk("rw_ir_clear", instr_word, 32'h0);
    step(); step();
    chk("rw_still_wait", {31'd0, instr_valid}, 32'd0);
    imem_valid = 1'b1; imem_rdata = 32'h2001_0005;
    step();
    imem_valid = 1'b0; imem_rdata = 32'h0;
    chk("rw_instruction", {26'd0, instruction}, 32'd8);
    chk("rw_instr_valid", {31'd0, instr_valid}, 32'd1);
    step();
    chk("rw_next_pc", pc, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
